// File: rtl/iob_rr_arbiter_pkg.sv
// iob_rr_arbiter_pkg: native-bus width/slice macros and FSM encoding shared by the arbiter files.
`ifndef IOB_RR_ARBITER_PKG_SV
`define IOB_RR_ARBITER_PKG_SV
`define IOB_REQ_W(A, D) (1 + (A) + (D) + (D) / 8)
`define IOB_RESP_W(D) ((D) + 1)
`define IOB_REQ_VALID(R, A, D) R[(A) + (D) + (D) / 8]
`define IOB_REQ_ADDR(R, A, D) R[(D) + (D) / 8 +: (A)]
`define IOB_REQ_WDATA(R, D) R[(D) / 8 +: (D)]
`define IOB_REQ_WSTRB(R, D) R[0 +: (D) / 8]
`define IOB_RESP_RDATA(R, D) R[1 +: (D)]
`define IOB_RESP_READY(R) R[0]
package iob_rr_arbiter_pkg;
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;
endpackage
`endif

// File: rtl/iob_rr_prio_enc.sv
// iob_rr_prio_enc: finds the first asserted request scanning upward from ptr+1 with wrap-around.
module iob_rr_prio_enc #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          found
);
    logic [IW-1:0] j;
    // Walk from the farthest candidate back to ptr+1 so the nearest hit wins.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        j     = '0;
        for (int k = N; k >= 1; k--) begin
            j = IW'((int'(ptr) + k) % N);
            if (req[j]) begin
                idx   = j;
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/iob_rr_arbiter.sv
// iob_rr_arbiter: round-robin native-bus arbiter locking one master per transaction onto the L2 port.
// Define ARB_CNT_EN to add per-master 32-bit completed-transaction counters on output cnt.
module iob_rr_arbiter
    import iob_rr_arbiter_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    localparam int REQ_W    = `IOB_REQ_W(ADDR_W, DATA_W),
    localparam int RESP_W   = `IOB_RESP_W(DATA_W),
    localparam int GW       = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_MASTERS*REQ_W-1:0]  m_req,
    output logic [N_MASTERS*RESP_W-1:0] m_resp,
    output logic [REQ_W-1:0]            s_req,
    input  logic [RESP_W-1:0]           s_resp,
    output logic [GW-1:0]               grant,
`ifdef ARB_CNT_EN
    output logic [N_MASTERS*32-1:0]     cnt,
`endif
    output logic                        busy
);
    arb_state_t           state_q, state_d;
    logic [GW-1:0]        grant_q, grant_d, last_q, last_d, win_idx;
    logic [N_MASTERS-1:0] valids;
    logic [REQ_W-1:0]     g_req;
    logic                 win_found, s_ready, g_valid;

    genvar i;
    for (i = 0; i < N_MASTERS; i++) begin : g_m
        assign valids[i] = m_req[i*REQ_W + REQ_W - 1];
        assign m_resp[i*RESP_W +: RESP_W] = (busy && grant_q == GW'(i)) ? s_resp : '0;
    end

    iob_rr_prio_enc #(.N(N_MASTERS), .IW(GW)) u_prio (
        .req   (valids),
        .ptr   (last_q),
        .idx   (win_idx),
        .found (win_found)
    );

    always_comb begin
        g_req = '0;
        for (int k = 0; k < N_MASTERS; k++)
            if (int'(grant_q) == k) g_req = m_req[k*REQ_W +: REQ_W];
    end

    assign s_ready = `IOB_RESP_READY(s_resp);
    assign g_valid = `IOB_REQ_VALID(g_req, ADDR_W, DATA_W);
    assign busy    = state_q == BUSY;
    assign grant   = grant_q;
    assign s_req   = busy ? g_req : '0;

    // Completion takes priority over an abort seen in the same cycle.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        if (state_q == IDLE) begin
            if (win_found) begin
                grant_d = win_idx;
                state_d = BUSY;
            end
        end else if (s_ready) begin
            state_d = IDLE;
            last_d  = grant_q;
        end else if (!g_valid) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= GW'(N_MASTERS - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

`ifdef ARB_CNT_EN
    logic [N_MASTERS*32-1:0] cnt_q, cnt_d;
    always_comb begin
        cnt_d = cnt_q;
        for (int k = 0; k < N_MASTERS; k++)
            if (busy && s_ready && int'(grant_q) == k) cnt_d[k*32 +: 32] = cnt_q[k*32 +: 32] + 32'd1;
    end
    always_ff @(posedge clk) begin
        cnt_q <= !rst ? '0 : cnt_d;
    end
    assign cnt = cnt_q;
`endif
endmodule

// File: tb/tb_iob_rr_arbiter.sv
// tb_iob_rr_arbiter: scoreboard bench for iob_rr_arbiter with two master drivers and an L2 slave model.
module tb_iob_rr_arbiter;
    localparam int N = 2, AW = 32, DW = 32, SW = DW / 8;
    localparam int REQ_W = 1 + AW + DW + SW, RESP_W = DW + 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] wstrb;
    } job_t;

    logic                clk = 1'b0, rst = 1'b0;
    logic [N*REQ_W-1:0]  m_req;
    logic [N*RESP_W-1:0] m_resp;
    logic [REQ_W-1:0]    s_req;
    logic [RESP_W-1:0]   s_resp = '0;
    logic                grant, busy;
`ifdef ARB_CNT_EN
    logic [N*32-1:0]     cnt;
`endif

    job_t          jq0[$], jq1[$];
    logic [DW-1:0] exp0[$], exp1[$];
    int            grant_log[$];
    job_t          cur[N];
    logic [N-1:0]  m_valid = '0, rdy_seen = '0, abort_req = '0, mv_prev = '0;
    int            n_checks = 0, n_fail = 0, lat = 2, scnt = 0, gap = 0;
    int            tb_cnt[N];
    bit            slave_auto = 1'b1;
    logic [RESP_W-1:0] man_resp = '0;
    logic [DW-1:0] popped;

    iob_rr_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk    (clk),
        .rst    (rst),
        .m_req  (m_req),
        .m_resp (m_resp),
        .s_req  (s_req),
        .s_resp (s_resp),
        .grant  (grant),
`ifdef ARB_CNT_EN
        .cnt    (cnt),
`endif
        .busy   (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] model_rdata(input logic [AW-1:0] a);
        return a ^ 32'hDEADBFEF;
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    always_comb begin
        m_req = '0;
        for (int i = 0; i < N; i++) m_req[i*REQ_W +: REQ_W] = {m_valid[i], cur[i]};
    end

    // Master drivers: hold a job until its ready cycle, then load the next queued one.
    initial begin
        for (int i = 0; i < N; i++) cur[i] = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (abort_req[i]) begin
                    m_valid[i] = 1'b0;
                    if (i == 0) popped = exp0.pop_front(); else popped = exp1.pop_front();
                end else if (!m_valid[i] || rdy_seen[i]) begin
                    m_valid[i] = 1'b0;
                    if (i == 0 && jq0.size() > 0) begin
                        cur[0] = jq0.pop_front();
                        m_valid[0] = 1'b1;
                        exp0.push_back(model_rdata(cur[0].addr));
                    end
                    if (i == 1 && jq1.size() > 0) begin
                        cur[1] = jq1.pop_front();
                        m_valid[1] = 1'b1;
                        exp1.push_back(model_rdata(cur[1].addr));
                    end
                end
            end
        end
    end

    // L2 slave model: ready `lat` cycles after valid, or a manually driven response.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!slave_auto) s_resp = man_resp;
            else if (s_req[REQ_W-1] && !s_resp[0]) begin
                scnt++;
                if (scnt >= lat) begin
                    s_resp = {model_rdata(s_req[REQ_W-2 -: AW]), 1'b1};
                    scnt = 0;
                end
            end else begin
                s_resp = '0;
                scnt = 0;
            end
        end
    end

    // Monitor: pops the scoreboard on every ready and checks routing and the valid gap.
    initial begin
        logic [DW-1:0] e;
        for (int i = 0; i < N; i++) tb_cnt[i] = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int i = 0; i < N; i++) tb_cnt[i] = 0;
                gap = 0;
            end
            if (gap == 1) check("gap_low", s_req[REQ_W-1], 1'b0);
            if (gap == 2 && mv_prev != '0) check("gap_one_cycle", s_req[REQ_W-1], 1'b1);
            if (gap > 0) gap = (gap == 2) ? 0 : 2;
            for (int i = 0; i < N; i++) begin
                rdy_seen[i] = m_resp[i*RESP_W];
                if (!(busy && int'(grant) == i)) check("nongrant_resp", m_resp[i*RESP_W +: RESP_W], '0);
                if (m_resp[i*RESP_W]) begin
                    check("rdy_grant", grant, i);
                    check("rdy_busy", busy, 1'b1);
                    check("rdy_sreq", s_req, {1'b1, cur[i]});
                    if ((i == 0 && exp0.size() == 0) || (i == 1 && exp1.size() == 0)) begin
                        check("spurious_rdy", 1'b1, 1'b0);
                    end else begin
                        if (i == 0) e = exp0.pop_front(); else e = exp1.pop_front();
                        check("rdata", m_resp[i*RESP_W+1 +: DW], e);
                    end
                    grant_log.push_back(i);
                    tb_cnt[i]++;
                    gap = 1;
                end
            end
            if (!busy) check("idle_sreq", s_req, '0);
            mv_prev = m_valid;
        end
    end

    task automatic push_job(input int m, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
        job_t j;
        j = '{addr: a, wdata: d, wstrb: s};
        if (m == 0) jq0.push_back(j); else jq1.push_back(j);
    endtask

    task automatic wait_idle();
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while ((busy || m_valid != '0 || jq0.size() != 0 || jq1.size() != 0) && t < 300);
        check("idle_timeout", t < 300, 1'b1);
    endtask

    task automatic wait_busy(input int g);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(busy && int'(grant) == g) && t < 100);
        check("busy_timeout", t < 100, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_grant", grant, 1'b0);
        check("rst_sreq", s_req, '0);
        check("rst_mresp", m_resp, '0);
        rst = 1'b1;

        // Single read from master 0, one-cycle arbitration latency.
        lat = 3;
        push_job(0, 32'h100, 32'h0, 4'h0);
        @(posedge clk);
        @(negedge clk);
        check("lat_pre", s_req[REQ_W-1], 1'b0);
        @(negedge clk);
        check("lat_valid", s_req[REQ_W-1], 1'b1);
        check("t1_grant", grant, 1'b0);
        wait_idle();
        check("t1_log_n", grant_log.size(), 1);
        check("t1_log", grant_log[0], 0);

        // Both masters continuously valid: strict alternation.
        do_reset();
        grant_log.delete();
        lat = 2;
        for (int k = 0; k < 4; k++) begin
            push_job(0, 32'h1000 + 32'(k * 4), 32'h0, 4'h0);
            push_job(1, 32'h2000 + 32'(k * 4), 32'h0, 4'h0);
        end
        wait_idle();
        check("alt_n", grant_log.size(), 8);
        for (int k = 0; k < 8; k++) check("alt_order", grant_log[k], k % 2);

        // Master 1 write passes through untouched.
        grant_log.delete();
        push_job(1, 32'h200, 32'h12345678, 4'hF);
        wait_busy(1);
        check("wr_sreq", s_req, {1'b1, 32'h200, 32'h12345678, 4'hF});
        check("wr_m0_resp", m_resp[0 +: RESP_W], '0);
        wait_idle();
        check("wr_log_n", grant_log.size(), 1);
        check("wr_log", grant_log[0], 1);

        // Reset mid-transaction; a late ready while idle must be discarded.
        slave_auto = 1'b0;
        man_resp = '0;
        push_job(1, 32'h300, 32'h0, 4'h0);
        wait_busy(1);
        rst = 1'b0;
        abort_req[1] = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        abort_req[1] = 1'b0;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_grant", grant, 1'b0);
        man_resp = {32'hCAFEF00D, 1'b1};
        @(negedge clk);
        @(negedge clk);
        check("late_rdy_sresp", s_resp[0], 1'b1);
        check("late_rdy_busy", busy, 1'b0);
        check("late_rdy_mresp", m_resp, '0);
        man_resp = '0;
        @(negedge clk);
        check("late_rdy_after", busy, 1'b0);
        slave_auto = 1'b1;
        grant_log.delete();
        push_job(0, 32'h310, 32'h0, 4'h0);
        push_job(1, 32'h320, 32'h0, 4'h0);
        wait_idle();
        check("post_rst_n", grant_log.size(), 2);
        check("post_rst_first", grant_log[0], 0);
        check("post_rst_second", grant_log[1], 1);

        // Granted master abandons its request before ready.
        lat = 8;
        grant_log.delete();
        push_job(0, 32'h400, 32'h0, 4'h0);
        wait_busy(0);
        push_job(1, 32'h500, 32'h0, 4'h0);
        @(negedge clk);
        @(negedge clk);
        abort_req[0] = 1'b1;
        @(posedge clk);
        #2;
        abort_req[0] = 1'b0;
        lat = 2;
        @(negedge clk);
        check("abort_hold", busy, 1'b1);
        @(negedge clk);
        check("abort_idle", busy, 1'b0);
        @(negedge clk);
        check("abort_regrant", busy, 1'b1);
        check("abort_grant", grant, 1'b1);
        wait_idle();
        check("abort_log_n", grant_log.size(), 1);
        check("abort_log", grant_log[0], 1);

        // Five master-0 and three master-1 transactions.
        do_reset();
        grant_log.delete();
        for (int k = 0; k < 5; k++) push_job(0, 32'h600 + 32'(k * 4), 32'h0, 4'h0);
        for (int k = 0; k < 3; k++) push_job(1, 32'h700 + 32'(k * 4), 32'h0, 4'h0);
        wait_idle();
        check("mix_n", grant_log.size(), 8);
        for (int k = 0; k < 8; k++) check("mix_order", grant_log[k], (k < 6) ? k % 2 : 0);
`ifdef ARB_CNT_EN
        check("cnt0", cnt[31:0], tb_cnt[0]);
        check("cnt1", cnt[63:32], tb_cnt[1]);
        check("cnt0_abs", cnt[31:0], 32'd5);
        check("cnt1_abs", cnt[63:32], 32'd3);
        do_reset();
        check("cnt0_rst", cnt[31:0], 32'd0);
        check("cnt1_rst", cnt[63:32], 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/iob_rr_arbiter.md
Name: iob_rr_arbiter

Overview:
Round-robin native-bus arbiter merging the instruction-cache and data-cache back-end buses into the single L2 cache front-end inside the external-memory subsystem. It locks one master per transaction, forwards that master's request to the slave port and routes the slave response back only to it. It replaces a fixed-priority merge so a streaming dcache cannot starve icache refills.

Parameters:
N_MASTERS, 2, number of master ports (2..8)
ADDR_W, 32, native address width (set to DCACHE_ADDR_W)
DATA_W, 32, native data width; WSTRB_W = DATA_W/8
(derived) REQ_W = 1+ADDR_W+DATA_W+WSTRB_W, packed {valid, addr, wdata, wstrb}; RESP_W = DATA_W+1, packed {rdata, ready}

Ports:
clk  in  1  system clock, single domain
rst  in  1  synchronous, active-low reset
m_req  in  N_MASTERS*REQ_W  master requests; master i occupies slice [i*REQ_W +: REQ_W]
m_resp  out  N_MASTERS*RESP_W  master responses, same slicing
s_req  out  REQ_W  request to L2 cache
s_resp  in  RESP_W  response from L2 cache
grant  out  $clog2(N_MASTERS) (min 1)  index of the locked master, valid when busy=1
busy  out  1  transaction in flight

Behaviour:
- Native protocol: master holds valid/addr/wdata/wstrb stable until ready pulses for one cycle; rdata valid only in the ready cycle.
- Reset (rst=0 at clk edge): state=IDLE, grant=0, last pointer=N_MASTERS-1 (master 0 wins first), busy=0, s_req all zero, m_resp all zero. Reset mid-transaction aborts it; the slave's later ready is discarded while IDLE.
- FSM IDLE: s_req valid=0, all m_resp=0. If any master valid, select first valid index scanning (last+1) mod N upward with wrap; register grant and enter BUSY. Arbitration latency: 1 cycle from valid to s_req valid.
- FSM BUSY: s_req = m_req[grant] (combinational pass-through); m_resp[grant] = s_resp; every other m_resp = 0 (ready=0, rdata=0).
- BUSY exit on s_resp ready=1: next state IDLE, last <= grant. s_req valid is therefore high in the ready cycle and low the next cycle, giving a guaranteed one-cycle valid gap (L2 invalidation depends on it). Back-to-back transactions cost 1 idle cycle.
- BUSY with granted master valid=0 (protocol violation/abort) and ready=0: return to IDLE next cycle; last unchanged.
- Simultaneous requests: the pointer guarantees strict alternation for N=2 when both are continuously valid.
- ready arriving while IDLE: ignored, never forwarded.
- Only the granted master's fields pass; non-granted inputs never reach s_req.

Optional Feature:
ARB_CNT_EN: when defined, adds output port cnt (N_MASTERS*32) of per-master 32-bit completed-transaction counters, incremented on the ready cycle for the granted master, wrapping at 2^32, cleared by reset. Without it, no counters or port exist; behaviour otherwise identical.

Decomposition:
- Shared package/header: REQ_W/RESP_W width macros, slice macros for valid/addr/wdata/wstrb/rdata/ready, FSM state encodings (IDLE=0, BUSY=1).
- One natural sub-module: iob_rr_prio_enc (combinational rotate-and-find-first from pointer, outputs index + found flag).

Test Plan:
- Reset then master 0 only valid, addr=0x100 read; L2 ready after 3 cycles with rdata=0xDEADBEEF -> s_req valid 1 cycle after m0 valid, m0 rdata=0xDEADBEEF with ready, m1 resp stays 0.
- Both masters valid continuously, L2 ready latency 2 -> grants alternate 0,1,0,1; s_req valid low exactly 1 cycle between each.
- Master 1 write wdata=0x12345678 wstrb=0xF while master 0 idle -> s_req carries m1 fields exactly, grant=1, m0 ready never asserted.
- rst=0 asserted mid-BUSY, L2 ready arrives 1 cycle after reset release -> ignored, busy=0, no master sees ready; next request from m0 and m1 together grants m0.
- Granted master drops valid before ready -> arbiter returns to IDLE next cycle, pending other master granted in the following cycle.
- ARB_CNT_EN: 5 transactions m0, 3 transactions m1 -> cnt[0]=5, cnt[1]=3; reset clears both to 0.
